// File: rtl/ac_goto_lookup.sv
// Linear goto-table search: hit at row k responds k+3 cycles after accept, full miss ENTRIES+2; response held until RSP_READY.
// AC_GOTO_SORTED_EN: table sorted by state, so the scan ends as a miss at the first row with a larger state.
module ac_goto_lookup #(
  parameter int ENTRIES = 32,
  parameter int ADDR_W  = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [7:0]        REQ_STATE,
  input  logic [3:0]        REQ_CHARA,
  output logic [ADDR_W-1:0] ADDR_G,
  input  logic [7:0]        RD_STATE,
  input  logic [3:0]        RD_CHARA,
  input  logic [7:0]        RD_NEXT,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [7:0]        RSP_NEXT,
  output logic              RSP_HIT,
  output logic              RSP_FAIL
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

  state_t            state, state_nxt;
  logic [7:0]        q_state;
  logic [3:0]        q_chara;
  logic [ADDR_W-1:0] addr_cnt;
  logic              issue_done;
  logic              rd_vld;
  logic              rd_last;
  logic              match;
  logic              past_key;
  logic              end_miss;
  logic [7:0]        rsp_next_q;
  logic              rsp_hit_q;
  logic              rsp_fail_q;

  // rd_vld/rd_last describe the row whose data is on RD_* this cycle
  always_comb begin
    match = (state == SCAN) && rd_vld && (RD_STATE == q_state) && (RD_CHARA == q_chara);
`ifdef AC_GOTO_SORTED_EN
    past_key = (state == SCAN) && rd_vld && (RD_STATE > q_state);
`else
    past_key = 1'b0;
`endif
    end_miss = (state == SCAN) && rd_vld && !match && (rd_last || past_key);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (REQ_VALID) state_nxt = SCAN;
      SCAN:    if (match || end_miss) state_nxt = DONE;
      DONE:    if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      q_state    <= '0;
      q_chara    <= '0;
      addr_cnt   <= '0;
      issue_done <= 1'b0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
      rsp_next_q <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_fail_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_vld  <= (state == SCAN) && !issue_done && !match && !end_miss;
      rd_last <= (addr_cnt == LAST_ADDR);
      if (state == IDLE && REQ_VALID) begin
        q_state    <= REQ_STATE;
        q_chara    <= REQ_CHARA;
        addr_cnt   <= '0;
        issue_done <= 1'b0;
      end
      // counter parks on the last row; issue_done stops further qualified reads
      if (state == SCAN) begin
        if (addr_cnt != LAST_ADDR) addr_cnt <= addr_cnt + 1'b1;
        else issue_done <= 1'b1;
      end
      if (match) begin
        rsp_next_q <= RD_NEXT;
        rsp_hit_q  <= 1'b1;
        rsp_fail_q <= 1'b0;
      end else if (end_miss) begin
        rsp_next_q <= '0;
        rsp_hit_q  <= 1'b0;
        rsp_fail_q <= (q_state != 8'd0);
      end
    end
  end

  assign REQ_READY = (state == IDLE);
  assign RSP_VALID = (state == DONE);
  assign ADDR_G    = addr_cnt;
  assign RSP_NEXT  = rsp_next_q;
  assign RSP_HIT   = rsp_hit_q;
  assign RSP_FAIL  = rsp_fail_q;

endmodule

// File: tb/tb_ac_goto_lookup.sv
// Bench for ac_goto_lookup: directed vector table, hand-written corner sequences, randomized queries vs. a table-scan model.
module tb_ac_goto_lookup;
  localparam int ENTRIES = 32;
  localparam int ADDR_W  = 12;

  logic              CLK = 1'b0;
  logic              RST;
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [7:0]        REQ_STATE;
  logic [3:0]        REQ_CHARA;
  logic [ADDR_W-1:0] ADDR_G;
  logic [7:0]        RD_STATE;
  logic [3:0]        RD_CHARA;
  logic [7:0]        RD_NEXT;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [7:0]        RSP_NEXT;
  logic              RSP_HIT;
  logic              RSP_FAIL;

  ac_goto_lookup #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_STATE(REQ_STATE), .REQ_CHARA(REQ_CHARA),
    .ADDR_G(ADDR_G), .RD_STATE(RD_STATE), .RD_CHARA(RD_CHARA), .RD_NEXT(RD_NEXT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_NEXT(RSP_NEXT), .RSP_HIT(RSP_HIT), .RSP_FAIL(RSP_FAIL)
  );

  always #5 CLK = ~CLK;

  logic [7:0] tst [ENTRIES];
  logic [3:0] tch [ENTRIES];
  logic [7:0] tnx [ENTRIES];

  // goto table RAM with one cycle read latency
  always @(posedge CLK) begin
    if (ADDR_G < ADDR_W'(ENTRIES)) begin
      RD_STATE <= tst[ADDR_G[4:0]];
      RD_CHARA <= tch[ADDR_G[4:0]];
      RD_NEXT  <= tnx[ADDR_G[4:0]];
    end else begin
      RD_STATE <= 8'hEE;
      RD_CHARA <= 4'hE;
      RD_NEXT  <= 8'hEE;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // first matching row wins; otherwise root miss maps to 0 with fail when state != 0
  function automatic void ref_model(input logic [7:0] s, input logic [3:0] c, output int lat,
                                    output logic [7:0] nx, output logic h, output logic f);
    lat = ENTRIES + 2;
    nx  = 8'd0;
    h   = 1'b0;
    f   = (s != 8'd0);
    for (int i = 0; i < ENTRIES; i++) begin
      if (tst[i] == s && tch[i] == c) begin
        lat = i + 3;
        nx  = tnx[i];
        h   = 1'b1;
        f   = 1'b0;
        return;
      end
`ifdef AC_GOTO_SORTED_EN
      if (tst[i] > s) begin
        lat = i + 3;
        return;
      end
`endif
    end
  endfunction

  // called at a negedge; returns at the negedge after the handshake edge
  task automatic run_query(input logic [7:0] s, input logic [3:0] c, input int hold,
                           output int lat, output logic [7:0] nx, output logic h,
                           output logic f, output bit ok);
    int guard = 0;
    ok = 1'b0;
    lat = 0; nx = '0; h = 1'b0; f = 1'b0;
    while (!REQ_READY && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (!REQ_READY) begin
      check("req_ready_timeout", 32'(REQ_READY), 32'd1);
      return;
    end
    REQ_VALID = 1'b1;
    REQ_STATE = s;
    REQ_CHARA = c;
    RSP_READY = 1'b0;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    REQ_STATE = 8'($urandom);
    REQ_CHARA = 4'($urandom);
    lat = 1;
    check("addr_cycle1", 32'(ADDR_G), 32'd0);
    while (!RSP_VALID && lat < ENTRIES + 20) begin
      @(negedge CLK);
      lat++;
    end
    if (!RSP_VALID) begin
      check("rsp_valid_timeout", 32'(RSP_VALID), 32'd1);
      return;
    end
    nx = RSP_NEXT;
    h  = RSP_HIT;
    f  = RSP_FAIL;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check("hold_valid", 32'(RSP_VALID), 32'd1);
      check("hold_next", 32'({RSP_NEXT, RSP_HIT, RSP_FAIL}), 32'({nx, h, f}));
      check("hold_req_ready", 32'(REQ_READY), 32'd0);
    end
    RSP_READY = 1'b1;
    @(negedge CLK);
    RSP_READY = 1'b0;
    ok = 1'b1;
  endtask

  typedef struct {
    logic [7:0] st;
    logic [3:0] ch;
    int         hold;
    logic       hit;
    logic [7:0] nx;
    logic       fail;
    int         lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int         lat, e_lat;
    logic [7:0] nx, e_nx;
    logic       h, f, e_h, e_f;
    bit         ok;
    int         sawv;

    RST = 1'b1; REQ_VALID = 1'b0; REQ_STATE = '0; REQ_CHARA = '0; RSP_READY = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      tst[i] = 8'h80 + 8'(i);
      tch[i] = 4'(i);
      tnx[i] = 8'hA0 + 8'(i);
    end
    tst[0] = 8'd0; tch[0] = 4'd1; tnx[0] = 8'd1;
    tst[1] = 8'd1; tch[1] = 4'd2; tnx[1] = 8'd2;
    tst[2] = 8'd2; tch[2] = 4'd3; tnx[2] = 8'd5;
    tst[3] = 8'd4; tch[3] = 4'd4; tnx[3] = 8'd9;
    tst[6] = 8'd4; tch[6] = 4'd4; tnx[6] = 8'd12;

    vecs[0] = '{st: 8'd1,    ch: 4'd2, hold: 10, hit: 1'b1, nx: 8'd2,    fail: 1'b0, lat: 4};
    vecs[1] = '{st: 8'd0,    ch: 4'd7, hold: 0,  hit: 1'b0, nx: 8'd0,    fail: 1'b0, lat: 34};
    vecs[2] = '{st: 8'd2,    ch: 4'd9, hold: 0,  hit: 1'b0, nx: 8'd0,    fail: 1'b1, lat: 34};
    vecs[3] = '{st: 8'd4,    ch: 4'd4, hold: 2,  hit: 1'b1, nx: 8'd9,    fail: 1'b0, lat: 6};
    vecs[4] = '{st: 8'd0,    ch: 4'd1, hold: 0,  hit: 1'b1, nx: 8'd1,    fail: 1'b0, lat: 3};
    vecs[5] = '{st: 8'd2,    ch: 4'd3, hold: 1,  hit: 1'b1, nx: 8'd5,    fail: 1'b0, lat: 5};
    vecs[6] = '{st: 8'h9F,   ch: 4'hF, hold: 0,  hit: 1'b1, nx: 8'hBF,   fail: 1'b0, lat: 34};
    vecs[7] = '{st: 8'h84,   ch: 4'h4, hold: 0,  hit: 1'b1, nx: 8'hA4,   fail: 1'b0, lat: 7};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("rst_addr", 32'(ADDR_G), 32'd0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_out", 32'({RSP_NEXT, RSP_HIT, RSP_FAIL}), 32'd0);
    check("rst_req_ready", 32'(REQ_READY), 32'd1);

`ifdef AC_GOTO_SORTED_EN
    for (int i = 0; i < ENTRIES; i++) begin
      tst[i] = 8'(i);
      tch[i] = 4'(i);
      tnx[i] = 8'h40 + 8'(i);
    end
    tst[0] = 8'd0; tst[1] = 8'd0; tst[2] = 8'd1; tst[3] = 8'd3; tst[4] = 8'd3;
    run_query(8'd2, 4'd1, 0, lat, nx, h, f, ok);
    if (ok) begin
      check("sorted_lat", 32'(lat), 32'd6);
      check("sorted_fail", 32'(f), 32'd1);
      check("sorted_hit", 32'(h), 32'd0);
      check("sorted_next", 32'(nx), 32'd0);
    end
`else
    foreach (vecs[i]) begin
      run_query(vecs[i].st, vecs[i].ch, vecs[i].hold, lat, nx, h, f, ok);
      if (ok) begin
        check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        check($sformatf("vec%0d_next", i), 32'(nx), 32'(vecs[i].nx));
        check($sformatf("vec%0d_hit", i), 32'(h), 32'(vecs[i].hit));
        check($sformatf("vec%0d_fail", i), 32'(f), 32'(vecs[i].fail));
        if (vecs[i].hold > 0) check($sformatf("vec%0d_b2b_ready", i), 32'(REQ_READY), 32'd1);
      end
    end
`endif

    // reset at scan cycle 5 drops the query silently
    REQ_VALID = 1'b1; REQ_STATE = 8'd2; REQ_CHARA = 4'd9;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("midrst_addr", 32'(ADDR_G), 32'd0);
    check("midrst_req_ready", 32'(REQ_READY), 32'd1);
    RSP_READY = 1'b1;
    sawv = 0;
    repeat (ENTRIES + 8) begin
      @(negedge CLK);
      if (RSP_VALID) sawv++;
    end
    check("midrst_no_stale", 32'(sawv), 32'd0);
    RSP_READY = 1'b0;

    // randomized tables and queries against the reference model
    for (int t = 0; t < 4; t++) begin
      logic [7:0] acc;
      acc = 8'd0;
      for (int i = 0; i < ENTRIES; i++) begin
`ifdef AC_GOTO_SORTED_EN
        acc = acc + 8'($urandom_range(0, 1));
        tst[i] = acc;
`else
        tst[i] = 8'($urandom_range(0, 7));
`endif
        tch[i] = 4'($urandom_range(0, 3));
        tnx[i] = 8'($urandom);
      end
      for (int q = 0; q < 12; q++) begin
        logic [7:0] qs;
        logic [3:0] qc;
        qs = 8'($urandom_range(0, 9));
        qc = 4'($urandom_range(0, 4));
        ref_model(qs, qc, e_lat, e_nx, e_h, e_f);
        run_query(qs, qc, $urandom_range(0, 3), lat, nx, h, f, ok);
        if (ok) begin
          check($sformatf("rnd_lat s=%0d c=%0d", qs, qc), 32'(lat), 32'(e_lat));
          check($sformatf("rnd_rsp s=%0d c=%0d", qs, qc), 32'({nx, h, f}), 32'({e_nx, e_h, e_f}));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
